// File: rtl/p2b_window_counter_pkg.sv
// Shared definitions for the pulse-to-binary window counter: data width,
// FSM state encoding and the count-to-output scale helper.
package p2b_window_counter_pkg;

  localparam int unsigned DATA_W = 16;

  typedef enum logic {
    IDLE  = 1'b0,
    COUNT = 1'b1
  } state_t;

  // Left shift that maps a one-count over 2^window_log2 samples onto DATA_W bits.
  function automatic int unsigned scale_shift(input int unsigned window_log2);
    return DATA_W - window_log2;
  endfunction

endpackage

// File: rtl/p2b_sat_scale.sv
// Scales a window one-count to the 16-bit probability scale; a full window
// (count == N) saturates to all ones instead of wrapping to zero.
module p2b_sat_scale
  import p2b_window_counter_pkg::*;
#(
  parameter int unsigned WINDOW_LOG2 = 8
) (
  input  logic [WINDOW_LOG2:0] ones_cnt,
  output logic [DATA_W-1:0]    scaled_c
);

  localparam int unsigned SHIFT = scale_shift(WINDOW_LOG2);

  // The MSB of the count is only set when every sample in the window was a one.
  always_comb begin
    scaled_c = DATA_W'(ones_cnt[WINDOW_LOG2-1:0]) << SHIFT;
    if (ones_cnt[WINDOW_LOG2]) begin
      scaled_c = '1;
    end
  end

endmodule

// File: rtl/p2b_window_counter.sv
// Counts ones on a stochastic bitstream over 2^WINDOW_LOG2 enabled samples
// and reports the scaled, saturated count with a one-cycle valid strobe.
module p2b_window_counter
  import p2b_window_counter_pkg::*;
#(
  parameter int unsigned WINDOW_LOG2 = 8,
  parameter bit          CONTINUOUS  = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              en,
  input  logic              pulsed_in,
  output logic [DATA_W-1:0] binary_out,
  output logic              out_valid,
  output logic              busy
);

  localparam int unsigned      CNT_W       = WINDOW_LOG2 + 1;
  localparam logic [CNT_W-1:0] LAST_SAMPLE = CNT_W'((1 << WINDOW_LOG2) - 1);

  state_t            state;
  state_t            state_next;
  logic [CNT_W-1:0]  sample_cnt;
  logic [CNT_W-1:0]  ones_cnt;
  logic [CNT_W-1:0]  ones_next;
  logic              sample_c;
  logic              done_c;
  logic              clear_c;
  logic [DATA_W-1:0] scaled_c;

  // Count including the sample taken at this edge, so completion sees the last bit.
  assign ones_next = ones_cnt + CNT_W'(pulsed_in);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = COUNT;
      COUNT:   if (done_c && !CONTINUOUS) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Per-state control strobes for the counters and the output register.
  always_comb begin
    sample_c = 1'b0;
    done_c   = 1'b0;
    clear_c  = 1'b0;
    case (state)
      IDLE:  clear_c = start;
      COUNT: begin
        sample_c = en;
        done_c   = en && (sample_cnt == LAST_SAMPLE);
      end
      default: ;
    endcase
  end

  p2b_sat_scale #(
    .WINDOW_LOG2(WINDOW_LOG2)
  ) u_sat_scale (
    .ones_cnt(ones_next),
    .scaled_c(scaled_c)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      sample_cnt <= '0;
      ones_cnt   <= '0;
      binary_out <= '0;
      out_valid  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      out_valid <= done_c;
      busy      <= (state_next == COUNT);
      if (done_c) begin
        binary_out <= scaled_c;
      end
      if (clear_c || done_c) begin
        sample_cnt <= '0;
        ones_cnt   <= '0;
      end else if (sample_c) begin
        sample_cnt <= sample_cnt + CNT_W'(1);
        ones_cnt   <= ones_next;
      end
    end
  end

endmodule

// File: tb/tb_p2b_window_counter.sv
// Bench for p2b_window_counter: four instances (N=256 one-shot, N=256
// continuous, N=2, N=65536) checked every cycle against a window-sum model.
module tb_p2b_window_counter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          active;
    int          n;
    int          ones;
    logic [15:0] out;
    bit          valid;
  } model_t;

  // a: N=256 one-shot, c: N=256 continuous, s: N=2, w: N=65536
  logic rst_a = 1'b1, start_a = 1'b0, en_a = 1'b0, pin_a = 1'b0;
  logic rst_c = 1'b1, start_c = 1'b0, en_c = 1'b0, pin_c = 1'b0;
  logic rst_s = 1'b1, start_s = 1'b0, en_s = 1'b0, pin_s = 1'b0;
  logic rst_w = 1'b1, start_w = 1'b0, en_w = 1'b0, pin_w = 1'b0;
  logic [15:0] out_a, out_c, out_s, out_w;
  logic val_a, val_c, val_s, val_w;
  logic busy_a, busy_c, busy_s, busy_w;

  p2b_window_counter #(.WINDOW_LOG2(8), .CONTINUOUS(1'b0)) dut_a (
    .clk(clk), .rst(rst_a), .start(start_a), .en(en_a), .pulsed_in(pin_a),
    .binary_out(out_a), .out_valid(val_a), .busy(busy_a));
  p2b_window_counter #(.WINDOW_LOG2(8), .CONTINUOUS(1'b1)) dut_c (
    .clk(clk), .rst(rst_c), .start(start_c), .en(en_c), .pulsed_in(pin_c),
    .binary_out(out_c), .out_valid(val_c), .busy(busy_c));
  p2b_window_counter #(.WINDOW_LOG2(1), .CONTINUOUS(1'b0)) dut_s (
    .clk(clk), .rst(rst_s), .start(start_s), .en(en_s), .pulsed_in(pin_s),
    .binary_out(out_s), .out_valid(val_s), .busy(busy_s));
  p2b_window_counter #(.WINDOW_LOG2(16), .CONTINUOUS(1'b0)) dut_w (
    .clk(clk), .rst(rst_w), .start(start_w), .en(en_w), .pulsed_in(pin_w),
    .binary_out(out_w), .out_valid(val_w), .busy(busy_w));

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  bit checking = 1'b0;
  bit done_w = 1'b0;

  model_t ma = '{default: 0};
  model_t mc = '{default: 0};
  model_t ms = '{default: 0};
  model_t mw = '{default: 0};

  int va_n = 0, va_cyc = 0;
  logic [15:0] va_val = 16'h0;
  int vs_n = 0;
  logic [15:0] vs_val = 16'h0;
  int vw_n = 0;
  logic [15:0] vw_val = 16'h0;
  int vc_q[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Window model: a window is a run of nw enabled samples after an accepted start.
  function automatic model_t mstep(input model_t m, input bit r, input bit s, input bit e,
                                   input bit p, input int nw, input bit cont);
    model_t q = m;
    if (r) begin
      q = '{default: 0};
      return q;
    end
    q.valid = 1'b0;
    if (!q.active) begin
      if (s) begin
        q.active = 1'b1;
        q.n = 0;
        q.ones = 0;
      end
    end else if (e) begin
      q.n = q.n + 1;
      q.ones = q.ones + int'(p);
      if (q.n == nw) begin
        q.out = (q.ones == nw) ? 16'hFFFF : 16'(q.ones * (65536 / nw));
        q.valid = 1'b1;
        q.n = 0;
        q.ones = 0;
        q.active = cont;
      end
    end
    return q;
  endfunction

  always @(posedge clk) begin
    ma <= mstep(ma, rst_a, start_a, en_a, pin_a, 256, 1'b0);
    mc <= mstep(mc, rst_c, start_c, en_c, pin_c, 256, 1'b1);
    ms <= mstep(ms, rst_s, start_s, en_s, pin_s, 2, 1'b0);
    mw <= mstep(mw, rst_w, start_w, en_w, pin_w, 65536, 1'b0);
    cyc <= cyc + 1;
  end

  task automatic cmp(input string t, input logic b, input logic v, input logic [15:0] o,
                     input model_t m);
    chk({t, "_busy"}, 32'(b), 32'(m.active));
    chk({t, "_valid"}, 32'(v), 32'(m.valid));
    chk({t, "_out"}, 32'(o), 32'(m.out));
  endtask

  always @(negedge clk) begin
    if (checking) begin
      cmp("a", busy_a, val_a, out_a, ma);
      cmp("c", busy_c, val_c, out_c, mc);
      cmp("s", busy_s, val_s, out_s, ms);
      cmp("w", busy_w, val_w, out_w, mw);
    end
  end

  // Strobe bookkeeping for the directed literal checks.
  always @(negedge clk) begin
    if (val_a === 1'b1) begin
      va_n <= va_n + 1;
      va_cyc <= cyc;
      va_val <= out_a;
    end
    if (val_s === 1'b1) begin
      vs_n <= vs_n + 1;
      vs_val <= out_s;
    end
    if (val_w === 1'b1) begin
      vw_n <= vw_n + 1;
      vw_val <= out_w;
    end
    if (val_c === 1'b1) vc_q.push_back(cyc);
  end

  task automatic drive_a(input bit s, input bit e, input bit p);
    @(negedge clk);
    start_a = s; en_a = e; pin_a = p;
  endtask

  task automatic drive_c(input bit s, input bit e, input bit p);
    @(negedge clk);
    start_c = s; en_c = e; pin_c = p;
  endtask

  task automatic drive_s(input bit s, input bit e, input bit p);
    @(negedge clk);
    start_s = s; en_s = e; pin_s = p;
  endtask

  // mode 0: all ones, 1: all zeros, 2: alternating 1,0, 3: en toggles, ones only while en=0
  task automatic run_a(input int mode, input int ncyc, output int lat, output int nval);
    int k;
    int n0;
    n0 = va_n;
    drive_a(1'b1, 1'b1, 1'b0);
    k = cyc + 1;
    for (int j = 0; j < ncyc; j++) begin
      case (mode)
        0: drive_a(1'b0, 1'b1, 1'b1);
        1: drive_a(1'b0, 1'b1, 1'b0);
        2: drive_a(1'b0, 1'b1, (j % 2) == 0);
        default: drive_a(1'b0, (j % 2) == 0, (j % 2) != 0);
      endcase
    end
    repeat (4) drive_a(1'b0, 1'b0, 1'b0);
    lat = va_cyc - k;
    nval = va_n - n0;
  endtask

  task automatic run_s(input bit p0, input bit p1, input logic [15:0] exp, input string nm);
    int n0;
    n0 = vs_n;
    drive_s(1'b1, 1'b1, 1'b0);
    drive_s(1'b0, 1'b1, p0);
    drive_s(1'b0, 1'b1, p1);
    repeat (3) drive_s(1'b0, 1'b0, 1'b0);
    chk({nm, "_val"}, 32'(vs_val), 32'(exp));
    chk({nm, "_cnt"}, 32'(vs_n - n0), 32'd1);
  endtask

  initial begin
    int lat;
    int nv;
    int k;
    repeat (3) @(negedge clk);
    rst_a = 1'b0; rst_c = 1'b0; rst_s = 1'b0; rst_w = 1'b0;
    checking = 1'b1;
    chk("reset_out", 32'(out_a), 32'h0);
    chk("reset_valid", 32'(val_a), 32'h0);
    chk("reset_busy", 32'(busy_a), 32'h0);

    fork
      begin
        @(negedge clk);
        start_w = 1'b1; en_w = 1'b1;
        @(negedge clk);
        start_w = 1'b0;
        for (int j = 0; j < 65536; j++) begin
          pin_w = ($urandom_range(65535) < 16384);
          @(negedge clk);
        end
        en_w = 1'b0;
        repeat (3) @(negedge clk);
        done_w = 1'b1;
      end
    join_none

    run_a(0, 256, lat, nv);
    chk("ones_val", 32'(va_val), 32'hFFFF);
    chk("ones_lat", 32'(lat), 32'd256);
    chk("ones_cnt", 32'(nv), 32'd1);

    run_a(1, 256, lat, nv);
    chk("zeros_val", 32'(va_val), 32'h0000);
    chk("zeros_cnt", 32'(nv), 32'd1);

    run_a(2, 256, lat, nv);
    chk("alt_val", 32'(va_val), 32'h8000);
    chk("alt_lat", 32'(lat), 32'd256);

    run_a(3, 512, lat, nv);
    chk("entog_val", 32'(va_val), 32'h0000);
    chk("entog_lat", 32'(lat), 32'd511);
    chk("entog_cnt", 32'(nv), 32'd1);

    // Reset after 100 samples of an all-ones window.
    nv = va_n;
    drive_a(1'b1, 1'b1, 1'b1);
    repeat (100) drive_a(1'b0, 1'b1, 1'b1);
    @(negedge clk);
    rst_a = 1'b1;
    @(negedge clk);
    rst_a = 1'b0; en_a = 1'b0;
    chk("rst_mid_out", 32'(out_a), 32'h0);
    chk("rst_mid_busy", 32'(busy_a), 32'h0);
    chk("rst_mid_valid", 32'(val_a), 32'h0);
    repeat (300) @(negedge clk);
    chk("rst_mid_noval", 32'(va_n - nv), 32'd0);
    run_a(0, 256, lat, nv);
    chk("post_rst_val", 32'(va_val), 32'hFFFF);
    chk("post_rst_lat", 32'(lat), 32'd256);

    // Continuous mode: 64 ones per window, stray start pulses while counting.
    drive_c(1'b1, 1'b1, 1'b0);
    k = cyc + 1;
    for (int j = 0; j < 768; j++) drive_c((j % 37) == 5, 1'b1, (j % 4) == 0);
    repeat (4) drive_c(1'b0, 1'b0, 1'b0);
    chk("cont_cnt", 32'(vc_q.size()), 32'd3);
    if (vc_q.size() == 3) begin
      chk("cont_first", 32'(vc_q[0] - k), 32'd256);
      chk("cont_gap1", 32'(vc_q[1] - vc_q[0]), 32'd256);
      chk("cont_gap2", 32'(vc_q[2] - vc_q[1]), 32'd256);
    end
    chk("cont_val", 32'(out_c), 32'h4000);
    chk("cont_busy", 32'(busy_c), 32'h1);

    run_s(1'b1, 1'b1, 16'hFFFF, "n2_11");
    run_s(1'b1, 1'b0, 16'h8000, "n2_10");
    run_s(1'b0, 1'b0, 16'h0000, "n2_00");
    run_s(1'b0, 1'b1, 16'h8000, "n2_01");

    for (int i = 0; i < 70000 && !done_w; i++) @(negedge clk);
    chk("w_done", 32'(done_w), 32'h1);
    chk("w_cnt", 32'(vw_n), 32'd1);
    chk("w_range", 32'(vw_val >= 16'h3E00 && vw_val <= 16'h4200), 32'h1);

    checking = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
